dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_if.sv | 31 +++
 rtl/dmem_access_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-RAM bundle between the MEM stage and dmem_access_ctrl.
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// resp_valid is a one-cycle pulse and resp_err/rdata are meaningful only with it.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mask_mode;
  logic        sext;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [2:0]  dbg_state;

  modport master (
    output req_valid, addr, wdata, mem_read, mem_write, mask_mode, sext, dm_rdata,
    input  req_ready, resp_valid, resp_err, rdata, dm_addr, dm_wdata, dm_we, dbg_state
  );

  modport slave (
    input  req_valid, addr, wdata, mem_read, mem_write, mask_mode, sext, dm_rdata,
    output req_ready, resp_valid, resp_err, rdata, dm_addr, dm_wdata, dm_we, dbg_state
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores against a
// one-cycle-latency word RAM, with read-modify-write for sub-word stores.
module dmem_access_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  dmem_access_ctrl_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  mode_q;
  logic        sext_q;
  logic        load_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic [4:0]  shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merge_val;
  logic        unused_addr;

  assign unused_addr   = &{1'b0, bus.addr[31:10]};
  assign bus.req_ready = (state == IDLE) & ~reset;
  assign bus.dbg_state = state;

  always_comb begin
    req_err = (bus.mem_read == bus.mem_write)
            | (bus.mask_mode == 2'b11)
            | ((bus.mask_mode == 2'b01) & bus.addr[0])
            | ((bus.mask_mode == 2'b10) & (bus.addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane merge for sub-word stores share the shift.
  always_comb begin
    shift    = (mode_q == 2'b00) ? {lane_q, 3'b000} : {lane_q[1], 4'b0000};
    byte_sel = 8'(bus.dm_rdata >> shift);
    half_sel = 16'(bus.dm_rdata >> shift);
    case (mode_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = bus.dm_rdata;
    endcase
    lane_mask = ((mode_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
    merge_val = (bus.dm_rdata & ~lane_mask) | ((wdata_q << shift) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.rdata      <= '0;
      bus.dm_addr    <= '0;
      bus.dm_wdata   <= '0;
      bus.dm_we      <= 1'b0;
      lane_q         <= '0;
      mode_q         <= '0;
      sext_q         <= 1'b0;
      load_q         <= 1'b0;
      wdata_q        <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.dm_we      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lane_q      <= bus.addr[1:0];
            mode_q      <= bus.mask_mode;
            sext_q      <= bus.sext;
            load_q      <= bus.mem_read;
            wdata_q     <= bus.wdata;
            bus.dm_addr <= {22'b0, bus.addr[9:2], 2'b00};
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.rdata      <= '0;
            end else if (bus.mem_write && bus.mask_mode == 2'b10) begin
              // Full-word stores need no read of the old word.
              state        <= WR;
              bus.dm_wdata <= bus.wdata;
              bus.dm_we    <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        RD:   state <= WAIT;
        WAIT: begin
          if (load_q) begin
            state          <= RESP;
            bus.rdata      <= load_val;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
          end else begin
            state        <= WR;
            bus.dm_wdata <= merge_val;
            bus.dm_we    <= 1'b1;
          end
        end
        WR: begin
          state          <= RESP;
          bus.rdata      <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
        end
        RESP: begin
          state        <= IDLE;
          bus.resp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: byte-addressed reference memory,
// expected responses and RAM writes queued at issue, popped by a monitor.
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  dmem_access_ctrl_if bus();

  dmem_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment word RAM with one-cycle read latency.
  logic [31:0] ram [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) ram[poke_idx] <= poke_data;
    else if (bus.dm_we) ram[bus.dm_addr[9:2]] <= bus.dm_wdata;
    bus.dm_rdata <= ram[bus.dm_addr[9:2]];
  end

  logic [7:0] ref_mem [1024];

  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t exp_q[$];
  wr_t   wexp_q[$];
  resp_t e_resp;
  wr_t   e_wr;

  int n_checks = 0;
  int n_fail = 0;
  int last_resp_cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ref_word(int idx);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[idx*4 + i];
    return v;
  endfunction

  // Reference behaviour from the access rules, on a byte-addressed memory.
  function automatic void model(logic [31:0] a, logic [31:0] w, logic r, logic wr,
                                logic [1:0] m, logic s, int acc);
    logic  err;
    int    n, base, lat;
    logic [31:0] v = '0;
    resp_t rr;
    wr_t   ww;
    err = (r == wr) || (m == 2'b11) || (m == 2'b01 && a[0]) || (m == 2'b10 && a[1:0] != 2'b00);
    n = 1 << m;
    base = int'(a[9:0]) / n * n;
    if (err) begin
      lat = 1;
    end else if (r) begin
      lat = 3;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
      if (n < 4 && s && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end else begin
      lat = (n == 4) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_mem[base + i] = w[8*i +: 8];
      ww.addr = {22'b0, a[9:2], 2'b00};
      ww.data = ref_word(int'(a[9:2]));
      ww.cyc  = acc + lat - 1;
      wexp_q.push_back(ww);
    end
    rr.err = err;
    rr.rdata = v;
    rr.cyc = acc + lat;
    exp_q.push_back(rr);
    last_resp_cyc = acc + lat;
  endfunction

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) check("unexpected_resp", {31'b0, bus.resp_valid}, 32'd0);
      else begin
        e_resp = exp_q.pop_front();
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, e_resp.err});
        check("rdata", bus.rdata, e_resp.rdata);
        check("resp_cycle", cyc, e_resp.cyc);
      end
    end
    if (bus.dm_we) begin
      if (wexp_q.size() == 0) check("unexpected_dm_we", {31'b0, bus.dm_we}, 32'd0);
      else begin
        e_wr = wexp_q.pop_front();
        check("dm_addr", bus.dm_addr, e_wr.addr);
        check("dm_wdata", bus.dm_wdata, e_wr.data);
        check("dm_we_cycle", cyc, e_wr.cyc);
      end
    end
  end

  task automatic poke(int idx, logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_idx = 8'(idx);
    poke_data = d;
    for (int i = 0; i < 4; i++) ref_mem[idx*4 + i] = d[8*i +: 8];
  endtask

  task automatic send(logic [31:0] a, logic [31:0] w, logic r, logic wr, logic [1:0] m, logic s);
    bit busy;
    int guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.addr = a;
    bus.wdata = w;
    bus.mem_read = r;
    bus.mem_write = wr;
    bus.mask_mode = m;
    bus.sext = s;
    busy = !bus.req_ready;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
    else begin
      if (busy) check("b2b_accept_cycle", cyc, last_resp_cyc + 1);
      model(a, w, r, wr, m, s, cyc);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0 || !bus.req_ready) && g < 30) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size() + wexp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_dm_addr", bus.dm_addr, 32'd0);
    check("rst_dm_wdata", bus.dm_wdata, 32'd0);
    check("rst_dm_we", {31'b0, bus.dm_we}, 32'd0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] saved;
    int k;
    bus.req_valid = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mask_mode = '0;
    bus.sext = 1'b0;

    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(4, 32'h80FF7F01);
    poke(8, 32'h11223344);
    @(negedge clk);
    poke_en = 1'b0;
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    send(32'h12, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
    wait_idle();
    check("byte_load_sext", bus.rdata, 32'hFFFFFFFF);
    send(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
    wait_idle();
    check("byte_load_zext", bus.rdata, 32'h00000080);

    send(32'h22, 32'hAAAABEEF, 1'b0, 1'b1, 2'b01, 1'b0);
    wait_idle();
    check("half_store_ram", ram[8], 32'hBEEF3344);
    check("store_rdata_zero", bus.rdata, 32'd0);

    send(32'h3C, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0);
    wait_idle();
    check("word_store_ram", ram[15], 32'hDEADBEEF);

    send(32'h06, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    wait_idle();
    send(32'h40, 32'h12345678, 1'b1, 1'b1, 2'b10, 1'b0);
    wait_idle();
    check("err_rdata_zero", bus.rdata, 32'd0);

    // Request held high across a load; second one must wait for IDLE.
    send(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    send(32'h12, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
    wait_idle();
    check("half_load_sext", bus.rdata, 32'hFFFF80FF);

    // Reset while a byte store sits in WAIT: the transaction must vanish.
    saved = ref_mem[32'h45];
    send(32'h45, 32'h000000A5, 1'b0, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    exp_q.delete();
    wexp_q.delete();
    ref_mem[32'h45] = saved;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'b0, bus.req_ready}, 32'd1);
    repeat (6) @(negedge clk);

    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 9);
      send($urandom, $urandom, (k < 4) || (k == 8), (k >= 4 && k < 8) || (k == 8),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    for (int i = 0; i < 256; i++) check("final_ram", ram[i], ref_word(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
